// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 initiator: turns a valid/ready command stream into
// SETUP/ACCESS transfers and returns one response per command.
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   apb_addr_o,
  output logic                    apb_sel_o,
  output logic                    apb_en_o,
  output logic                    apb_wr_o,
  output logic [DATA_WIDTH-1:0]   apb_wdata_o,
  output logic [DATA_WIDTH/8-1:0] apb_strb_o,
  input  logic [DATA_WIDTH-1:0]   apb_rdata_i,
  input  logic                    apb_ready_i,
  input  logic                    apb_err_i,
  output logic [1:0]              dbg_state_o
);
  // Handshakes: a command moves when cmd_valid_i && cmd_ready_o on a rising
  // edge; a response moves when rsp_valid_o && rsp_ready_i. Once raised,
  // rsp_valid_o and all rsp_* fields hold until the handshake.
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sel_q, sel_d;
  logic                  en_q, en_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    en_d     = en_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wr_d    = cmd_write_i;
          wdata_d = cmd_wdata_i;
          strb_d  = cmd_write_i ? cmd_strb_i : '0;
          sel_d   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb_ready_i) begin
          rdata_d  = wr_q ? '0 : apb_rdata_i;
          err_d    = apb_err_i;
          tmo_d    = 1'b0;
          sel_d    = 1'b0;
          en_d     = 1'b0;
          strb_d   = '0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th ACCESS cycle without PREADY.
          rdata_d  = '0;
          err_d    = 1'b1;
          tmo_d    = 1'b1;
          sel_d    = 1'b0;
          en_d     = 1'b0;
          strb_d   = '0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = rvalid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign apb_addr_o    = addr_q;
  assign apb_sel_o     = sel_q;
  assign apb_en_o      = en_q;
  assign apb_wr_o      = wr_q;
  assign apb_wdata_o   = wdata_q;
  assign apb_strb_o    = strb_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: each task drives one scenario and checks
// the APB pins and response channel against hand-computed values.
module tb_apb_cmd_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [SW-1:0] cmd_strb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] apb_addr_o;
  logic          apb_sel_o;
  logic          apb_en_o;
  logic          apb_wr_o;
  logic [DW-1:0] apb_wdata_o;
  logic [SW-1:0] apb_strb_o;
  logic [DW-1:0] apb_rdata_i;
  logic          apb_ready_i;
  logic          apb_err_i;
  logic [1:0]    dbg_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .apb_addr_o(apb_addr_o), .apb_sel_o(apb_sel_o), .apb_en_o(apb_en_o),
    .apb_wr_o(apb_wr_o), .apb_wdata_o(apb_wdata_o), .apb_strb_o(apb_strb_o),
    .apb_rdata_i(apb_rdata_i), .apb_ready_i(apb_ready_i), .apb_err_i(apb_err_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
  endtask

  task automatic handshake_rsp();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_handshake: valid=%b ready=%b, required valid=0 ready=1", rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_strb_i = '0;
    rsp_ready_i = 1'b0; apb_rdata_i = '0; apb_ready_i = 1'b0; apb_err_i = 1'b0;
    #12;
    n_cmp++;
    if ({apb_sel_o, apb_en_o, apb_wr_o, apb_addr_o, apb_wdata_o, apb_strb_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_apb: sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h, required all 0",
               apb_sel_o, apb_en_o, apb_wr_o, apb_addr_o, apb_wdata_o, apb_strb_o);
    end
    n_cmp++;
    if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp: valid=%b err=%b tmo=%b rdata=%h, required all 0",
               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || dbg_state_o !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_ready: cmd_ready=%b state=%0d, required 1 / 0", cmd_ready_o, dbg_state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_write();
    apb_ready_i = 1'b1;
    drive_cmd(1'b1, 8'h10, 32'hA5A5_0001, 4'hF);
    tick();
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (apb_sel_o !== 1'b1 || apb_en_o !== 1'b0 || apb_addr_o !== 8'h10 || apb_wr_o !== 1'b1 ||
        apb_wdata_o !== 32'hA5A5_0001 || apb_strb_o !== 4'hF || cmd_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_setup: sel=%b en=%b addr=%h wr=%b wdata=%h strb=%h crdy=%b, required 1 0 10 1 a5a50001 f 0",
               apb_sel_o, apb_en_o, apb_addr_o, apb_wr_o, apb_wdata_o, apb_strb_o, cmd_ready_o);
    end
    tick();
    n_cmp++;
    if (apb_sel_o !== 1'b1 || apb_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_access: sel=%b en=%b rvalid=%b, required 1 1 0", apb_sel_o, apb_en_o, rsp_valid_o);
    end
    tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
        apb_sel_o !== 1'b0 || apb_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp: rvalid=%b err=%b tmo=%b rdata=%h sel=%b en=%b, required 1 0 0 0 0 0",
               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, apb_sel_o, apb_en_o);
    end
    n_cmp++;
    if (apb_strb_o !== 4'h0 || apb_addr_o !== 8'h10 || apb_wdata_o !== 32'hA5A5_0001 || apb_wr_o !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_after: strb=%h addr=%h wdata=%h wr=%b, required 0 10 a5a50001 1",
               apb_strb_o, apb_addr_o, apb_wdata_o, apb_wr_o);
    end
    handshake_rsp();
  endtask

  task automatic test_read_wait();
    apb_ready_i = 1'b0;
    apb_err_i   = 1'b1;  // PSLVERR without PREADY must be ignored
    apb_rdata_i = 32'hDEAD_BEEF;
    drive_cmd(1'b0, 8'h04, 32'h1111_2222, 4'hF);
    tick();
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (apb_sel_o !== 1'b1 || apb_wr_o !== 1'b0 || apb_strb_o !== 4'h0 || apb_addr_o !== 8'h04) begin
      n_bad++;
      $display("FAIL rd_setup: sel=%b wr=%b strb=%h addr=%h, required 1 0 0 04",
               apb_sel_o, apb_wr_o, apb_strb_o, apb_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (apb_sel_o !== 1'b1 || apb_en_o !== 1'b1 || rsp_valid_o !== 1'b0 ||
          apb_strb_o !== 4'h0 || apb_addr_o !== 8'h04) begin
        n_bad++;
        $display("FAIL rd_wait%0d: sel=%b en=%b rvalid=%b strb=%h addr=%h, required 1 1 0 0 04",
                 i, apb_sel_o, apb_en_o, rsp_valid_o, apb_strb_o, apb_addr_o);
      end
    end
    apb_ready_i = 1'b1;
    apb_err_i   = 1'b0;
    apb_rdata_i = 32'h0000_0055;
    tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h55 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp: rvalid=%b rdata=%h err=%b tmo=%b, required 1 55 0 0",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o);
    end
    handshake_rsp();
  endtask

  task automatic test_slave_error();
    apb_ready_i = 1'b1;
    apb_err_i   = 1'b1;
    drive_cmd(1'b1, 8'hFC, 32'h0BAD_0BAD, 4'h3);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_timeout_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL slverr_rsp: rvalid=%b err=%b tmo=%b rdata=%h, required 1 1 0 0",
               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
    end
    handshake_rsp();
    apb_err_i   = 1'b0;
    apb_rdata_i = 32'h1234_5678;
    drive_cmd(1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1234_5678 || apb_addr_o !== 8'h00) begin
      n_bad++;
      $display("FAIL after_err_rd: rvalid=%b err=%b rdata=%h addr=%h, required 1 0 12345678 00",
               rsp_valid_o, rsp_err_o, rsp_rdata_o, apb_addr_o);
    end
    handshake_rsp();
  endtask

  task automatic test_timeout();
    int en_cycles;
    en_cycles = 0;
    apb_ready_i = 1'b0;
    apb_rdata_i = 32'hFFFF_FFFF;
    drive_cmd(1'b0, 8'h40, 32'h0, 4'h0);
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (apb_en_o === 1'b1) en_cycles++;
      else break;
    end
    n_cmp++;
    if (en_cycles !== 16) begin
      n_bad++;
      $display("FAIL tmo_en_cycles: penable high %0d cycles, required 16", en_cycles);
    end
    n_cmp++;
    if (apb_sel_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 ||
        rsp_timeout_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL tmo_rsp: sel=%b rvalid=%b err=%b tmo=%b rdata=%h, required 0 1 1 1 0",
               apb_sel_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
    end
    handshake_rsp();
  endtask

  task automatic test_backpressure();
    apb_ready_i = 1'b1;
    drive_cmd(1'b1, 8'h20, 32'hCAFE_0020, 4'h5);
    tick();
    // Valid stays high; new fields must not disturb the transfer in flight.
    drive_cmd(1'b1, 8'h30, 32'hCAFE_0030, 4'hA);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0 ||
          rsp_rdata_o !== 32'h0 || cmd_ready_o !== 1'b0 || apb_addr_o !== 8'h20 ||
          apb_wdata_o !== 32'hCAFE_0020) begin
        n_bad++;
        $display("FAIL bp_hold%0d: rvalid=%b err=%b tmo=%b rdata=%h crdy=%b addr=%h wdata=%h, required 1 0 0 0 0 20 cafe0020",
                 i, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, cmd_ready_o, apb_addr_o, apb_wdata_o);
      end
      tick();
    end
    handshake_rsp();
    tick();
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (apb_sel_o !== 1'b1 || apb_en_o !== 1'b0 || apb_addr_o !== 8'h30 ||
        apb_wdata_o !== 32'hCAFE_0030 || apb_strb_o !== 4'hA || cmd_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_next_accept: sel=%b en=%b addr=%h wdata=%h strb=%h crdy=%b, required 1 0 30 cafe0030 a 0",
               apb_sel_o, apb_en_o, apb_addr_o, apb_wdata_o, apb_strb_o, cmd_ready_o);
    end
    tick();
    tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_second_rsp: rvalid=%b err=%b, required 1 0", rsp_valid_o, rsp_err_o);
    end
    handshake_rsp();
  endtask

  task automatic test_reset_mid_access();
    apb_ready_i = 1'b0;
    drive_cmd(1'b0, 8'h08, 32'h0, 4'h0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (apb_sel_o !== 1'b0 || apb_en_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: sel=%b en=%b rvalid=%b crdy=%b, required 0 0 0 1",
               apb_sel_o, apb_en_o, rsp_valid_o, cmd_ready_o);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    apb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (rsp_valid_o !== 1'b0 || apb_sel_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_no_stray%0d: rvalid=%b sel=%b crdy=%b, required 0 0 1",
                 i, rsp_valid_o, apb_sel_o, cmd_ready_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB4 initiator: the requester end of the register bus that the UART's APB slave port responds to.
- Converts a valid/ready command stream (from a CPU-side bridge or a bench sequencer) into compliant SETUP/ACCESS transfers.
- Handles PREADY wait states, PSLVERR and a hung-slave timeout, and returns one response per command on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 8, width of command and APB address.
- DATA_WIDTH, 32, width of data buses (multiple of 8).
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (>=1).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- cmd_strb_i  in  DATA_WIDTH/8  byte strobes (writes only).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err_o  out  1  PSLVERR seen, or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- apb_addr_o  out  ADDR_WIDTH  PADDR.
- apb_sel_o  out  1  PSEL.
- apb_en_o  out  1  PENABLE.
- apb_wr_o  out  1  PWRITE.
- apb_wdata_o  out  DATA_WIDTH  PWDATA.
- apb_strb_o  out  DATA_WIDTH/8  PSTRB.
- apb_rdata_i  in  DATA_WIDTH  PRDATA.
- apb_ready_i  in  1  PREADY.
- apb_err_i  in  1  PSLVERR.

Behaviour:
- Reset (async assert):
  - state = IDLE.
  - All apb_* outputs = 0.
  - rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_rdata_o = 0; timeout counter = 0.
  - cmd_ready_o = 1 (it is a decode of state == IDLE).
- FSM states IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, register addr, write, wdata and strb onto the apb_* outputs (strb forced to 0 for reads); set apb_sel_o = 1; go to SETUP.
- SETUP (one cycle):
  - apb_sel_o = 1, apb_en_o = 0.
  - Next: ACCESS with apb_en_o = 1; timeout counter cleared.
- ACCESS:
  - apb_sel_o = apb_en_o = 1; addr, write, wdata and strb held stable.
  - If apb_ready_i:
    - capture apb_rdata_i (reads) or 0 (writes) into rsp_rdata_o;
    - rsp_err_o = apb_err_i, rsp_timeout_o = 0;
    - deassert sel/en; rsp_valid_o = 1; go to RESP.
  - Else increment the counter. When TIMEOUT ACCESS cycles have elapsed with no PREADY:
    - deassert sel/en; rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0;
    - go to RESP.
  - apb_err_i is ignored unless apb_ready_i is high.
- RESP:
  - rsp_valid_o held with all rsp_* outputs stable until rsp_ready_i.
  - On handshake: rsp_valid_o = 0, go to IDLE.
  - cmd_ready_o = 0 in SETUP, ACCESS and RESP (one outstanding transfer only).
- Latency:
  - Accept at edge N -> PSEL at N+1, PENABLE at N+2.
  - With zero wait states, rsp_valid_o is high from edge N+3.
  - Each wait state adds 1 cycle.
  - Next command is accepted no earlier than 1 cycle after the response handshake.
- After a transfer, apb_addr_o, apb_wr_o and apb_wdata_o keep their last values; apb_strb_o returns to 0.
- Reset mid-transfer: immediate abort, no response issued, PSEL/PENABLE low asynchronously.
- Command fields are sampled only on the accepting edge; later changes are ignored.

Test Plan:
- Zero-wait write: cmd addr 0x10, wdata 0xA5A5_0001, strb 0xF; PREADY tied 1 -> PSEL at N+1, PENABLE at N+2, PWDATA 0xA5A5_0001, PSTRB 0xF; rsp_valid at N+3 with err 0, rdata 0.
- Read with 2 wait states: addr 0x04; slave holds PREADY low for 2 ACCESS cycles, then PRDATA 0x0000_0055 -> rsp_rdata 0x55, rsp_valid at N+5, PSTRB 0 throughout, addr stable.
- Slave error: write to 0xFC; PREADY=1 with PSLVERR=1 -> rsp_err 1, rsp_timeout 0; a following read to 0x00 completes with rsp_err 0.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> PENABLE high exactly 16 cycles, then PSEL/PENABLE drop; rsp_err 1, rsp_timeout 1, rdata 0.
- Backpressure: rsp_ready low for 5 cycles with cmd_valid held high -> rsp_* stable and cmd_ready 0 for all 5 cycles; next command is accepted the cycle after the handshake.
- Reset mid-ACCESS: assert rst_n=0 during a wait state -> PSEL, PENABLE and rsp_valid go 0 immediately, cmd_ready 1; no stray response after rst_n is released.
